// File: rtl/edge_arb_pkg.sv
// Shared types, constants and helpers for the edge-event arbiter family.
//   EVT_RISE / EVT_FALL : encoding of the event type bit
//   edge_evt_t          : event payload {ch, fall}, ch sized for up to 16 channels
//   rr_next             : round-robin index increment with wrap at n
package edge_arb_pkg;

    localparam int unsigned CH_W_MAX = 4;

    localparam logic EVT_RISE = 1'b0;
    localparam logic EVT_FALL = 1'b1;

    typedef struct packed {
        logic [CH_W_MAX-1:0] ch;
        logic                fall;
    } edge_evt_t;

    // Next index after idx, wrapping to 0 at n.
    function automatic logic [CH_W_MAX-1:0] rr_next(input logic [CH_W_MAX-1:0] idx,
                                                    input int unsigned         n);
        if (32'(idx) + 32'd1 >= n) begin
            return '0;
        end
        return idx + CH_W_MAX'(1);
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Event output handshake bundle.
//   evt_valid : event available (master drives)
//   evt_ready : consumer accepts event (slave drives)
//   evt_ch    : channel of the presented event
//   evt_fall  : 0 = rising edge, 1 = falling edge
interface edge_event_arbiter_if #(
    parameter int unsigned N_CH = 4
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic            evt_ready;
    logic [CH_W-1:0] evt_ch;
    logic            evt_fall;

    modport master (output evt_valid, output evt_ch, output evt_fall, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, input evt_fall, output evt_ready);
endinterface

// File: rtl/edge_arb_rr_pick.sv
// Combinational round-robin picker.
//   req_i       : request vector
//   ptr_i       : index of the last winner; the search starts one past it
//   win_idx_c_o : first requesting index found, wrapping modulo N_CH
//   any_req_c_o : at least one request present
module edge_arb_rr_pick
    import edge_arb_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic [N_CH-1:0]          req_i,
    input  logic [$clog2(N_CH)-1:0]  ptr_i,
    output logic [$clog2(N_CH)-1:0]  win_idx_c_o,
    output logic                     any_req_c_o
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [CH_W_MAX-1:0] cur;

    always_comb begin
        win_idx_c_o = '0;
        any_req_c_o = 1'b0;
        cur         = rr_next(CH_W_MAX'(ptr_i), N_CH);
        for (int k = 0; k < int'(N_CH); k++) begin
            if (!any_req_c_o && req_i[cur[CH_W-1:0]]) begin
                any_req_c_o = 1'b1;
                win_idx_c_o = cur[CH_W-1:0];
            end
            cur = rr_next(cur, N_CH);
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Per-channel edge detector with one pending slot per channel, round-robin
// arbitration onto a single registered valid/ready event port.
//   clk, rst : clock, synchronous active-high reset
//   sig      : monitored signals
//   en_rise  : per-channel rising-edge enable
//   en_fall  : per-channel falling-edge enable
//   evt      : event port (master modport of edge_event_arbiter_if)
//   pend     : per-channel pending slot occupied
//   ovf      : sticky per-channel overflow
//   ovf_clr  : per-channel overflow clear (write-1-to-clear)
// Build option EDGE_ARB_SYNC_EN: inserts a 2-flop synchronizer per channel and
// suppresses detection for 3 cycles after reset while the history primes.
module edge_event_arbiter
    import edge_arb_pkg::*;
#(
    parameter int unsigned N_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         sig,
    input  logic [N_CH-1:0]         en_rise,
    input  logic [N_CH-1:0]         en_fall,
    edge_event_arbiter_if.master    evt,
    output logic [N_CH-1:0]         pend,
    output logic [N_CH-1:0]         ovf,
    input  logic [N_CH-1:0]         ovf_clr
);
    localparam int unsigned CH_W = $clog2(N_CH);

    logic [N_CH-1:0] sig_s;
    logic            det_en;

`ifdef EDGE_ARB_SYNC_EN
    logic [N_CH-1:0] sync1_q;
    logic [N_CH-1:0] sync2_q;
    logic [1:0]      prime_q;

    // Synchronizer flops intentionally carry no reset.
    always_ff @(posedge clk) begin
        sync1_q <= sig;
        sync2_q <= sync1_q;
    end

    // Hold off detection until the synchronizer and history register are primed.
    always_ff @(posedge clk) begin
        if (rst) begin
            prime_q <= '0;
        end else if (prime_q != 2'd3) begin
            prime_q <= prime_q + 2'd1;
        end
    end

    assign sig_s  = sync2_q;
    assign det_en = (prime_q == 2'd3);
`else
    assign sig_s  = sig;
    assign det_en = 1'b1;
`endif

    logic [N_CH-1:0] sig_q;
    logic [N_CH-1:0] occ_q, occ_d;
    logic [N_CH-1:0] typ_q, typ_d;
    logic [N_CH-1:0] ovf_q, ovf_d;
    logic            vld_q, vld_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            fall_q, fall_d;
    logic [CH_W-1:0] ptr_q, ptr_d;

    logic [N_CH-1:0] rise_c, fall_c, edge_c, gnt_c;
    logic [CH_W-1:0] win_c;
    logic            any_c;
    logic            free_c;

    edge_arb_rr_pick #(.N_CH(N_CH)) u_pick (
        .req_i       (occ_q),
        .ptr_i       (ptr_q),
        .win_idx_c_o (win_c),
        .any_req_c_o (any_c)
    );

    // Edge detection, slot update and output register next state.
    always_comb begin
        rise_c = '0;
        fall_c = '0;
        edge_c = '0;
        gnt_c  = '0;
        occ_d  = occ_q;
        typ_d  = typ_q;
        ovf_d  = ovf_q;
        vld_d  = vld_q;
        ch_d   = ch_q;
        fall_d = fall_q;
        ptr_d  = ptr_q;

        free_c = !vld_q || evt.evt_ready;

        if (det_en) begin
            rise_c = sig_s & ~sig_q & en_rise;
            fall_c = ~sig_s & sig_q & en_fall;
        end
        edge_c = rise_c | fall_c;

        for (int i = 0; i < int'(N_CH); i++) begin
            gnt_c[i] = free_c && any_c && (win_c == CH_W'(i));
        end

        // A slot being granted this cycle can accept a new edge at the same edge.
        for (int i = 0; i < int'(N_CH); i++) begin
            if (edge_c[i] && (!occ_q[i] || gnt_c[i])) begin
                occ_d[i] = 1'b1;
                typ_d[i] = fall_c[i] ? EVT_FALL : EVT_RISE;
            end else if (gnt_c[i]) begin
                occ_d[i] = 1'b0;
            end

            // Overflow set wins over a same-cycle clear.
            if (edge_c[i] && occ_q[i] && !gnt_c[i]) begin
                ovf_d[i] = 1'b1;
            end else if (ovf_clr[i]) begin
                ovf_d[i] = 1'b0;
            end
        end

        if (free_c) begin
            if (any_c) begin
                vld_d  = 1'b1;
                ch_d   = win_c;
                fall_d = typ_q[win_c];
                ptr_d  = win_c;
            end else begin
                vld_d  = 1'b0;
            end
        end
    end

    // State registers; the history register tracks sig even during reset.
    always_ff @(posedge clk) begin
        sig_q <= sig_s;
        if (rst) begin
            occ_q  <= '0;
            typ_q  <= '0;
            ovf_q  <= '0;
            vld_q  <= 1'b0;
            ch_q   <= '0;
            fall_q <= 1'b0;
            ptr_q  <= CH_W'(N_CH - 1);
        end else begin
            occ_q  <= occ_d;
            typ_q  <= typ_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
            ch_q   <= ch_d;
            fall_q <= fall_d;
            ptr_q  <= ptr_d;
        end
    end

    assign evt.evt_valid = vld_q;
    assign evt.evt_ch    = ch_q;
    assign evt.evt_fall  = fall_q;
    assign pend          = occ_q;
    assign ovf           = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (default build, N_CH=4).
module tb_edge_event_arbiter;
    import edge_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sig;
    logic [3:0] en_rise;
    logic [3:0] en_fall;
    logic [3:0] pend;
    logic [3:0] ovf;
    logic [3:0] ovf_clr;

    int n_cmp = 0;
    int n_bad = 0;

    edge_event_arbiter_if #(.N_CH(4)) evt_if ();

    edge_event_arbiter #(.N_CH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sig     (sig),
        .en_rise (en_rise),
        .en_fall (en_fall),
        .evt     (evt_if),
        .pend    (pend),
        .ovf     (ovf),
        .ovf_clr (ovf_clr)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are stable 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sig = 4'b1111;
        en_rise = 4'hF;
        en_fall = 4'hF;
        ovf_clr = 4'h0;
        evt_if.evt_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_cmp++;
            if ({evt_if.evt_valid, pend, ovf} !== 9'b0_0000_0000) begin
                $display("FAIL reset_quiet cyc%0d: valid=%b pend=%b ovf=%b, want 0/0000/0000",
                         c, evt_if.evt_valid, pend, ovf);
                n_bad++;
            end
        end
    endtask

    task automatic test_single_rise();
        // Bring sig low with edges disabled; nothing may be queued.
        en_rise = 4'h0;
        en_fall = 4'h0;
        sig = 4'b0000;
        repeat (2) tick();
        n_cmp++;
        if ({evt_if.evt_valid, pend} !== 5'b0_0000) begin
            $display("FAIL disabled_drop: valid=%b pend=%b, want 0/0000", evt_if.evt_valid, pend);
            n_bad++;
        end
        en_rise = 4'hF;
        en_fall = 4'hF;
        sig = 4'b0100;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, pend} !== 5'b0_0100) begin
            $display("FAIL single_pend: valid=%b pend=%b, want 0/0100", evt_if.evt_valid, pend);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend} !== {1'b1, 2'd2, EVT_RISE, 4'b0000}) begin
            $display("FAIL single_evt: valid=%b ch=%0d fall=%b pend=%b, want 1/2/0/0000",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (evt_if.evt_valid !== 1'b0) begin
            $display("FAIL single_drop: valid=%b, want 0", evt_if.evt_valid);
            n_bad++;
        end
    endtask

    task automatic test_burst();
        logic [3:0] lvl [2];
        lvl[0] = 4'b1111;
        lvl[1] = 4'b0000;
        // Fresh reset so the pointer starts at ch3 and ch0 leads.
        rst = 1'b1;
        sig = 4'b0000;
        tick();
        rst = 1'b0;
        tick();
        for (int r = 0; r < 2; r++) begin
            sig = lvl[r];
            tick();
            n_cmp++;
            if ({evt_if.evt_valid, pend} !== 5'b0_1111) begin
                $display("FAIL burst_pend r%0d: valid=%b pend=%b, want 0/1111", r, evt_if.evt_valid, pend);
                n_bad++;
            end
            for (int k = 0; k < 4; k++) begin
                tick();
                n_cmp++;
                if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall} !== {1'b1, 2'(k), 1'(r)}) begin
                    $display("FAIL burst_evt r%0d k%0d: valid=%b ch=%0d fall=%b, want 1/%0d/%0d",
                             r, k, evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, k, r);
                    n_bad++;
                end
            end
            tick();
            n_cmp++;
            if ({evt_if.evt_valid, pend} !== 5'b0_0000) begin
                $display("FAIL burst_idle r%0d: valid=%b pend=%b, want 0/0000", r, evt_if.evt_valid, pend);
                n_bad++;
            end
        end
    endtask

    task automatic test_overflow();
        evt_if.evt_ready = 1'b0;
        sig = 4'b0010;
        tick();
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend} !== {1'b1, 2'd1, EVT_RISE, 4'b0000}) begin
            $display("FAIL ovf_first: valid=%b ch=%0d fall=%b pend=%b, want 1/1/0/0000",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend);
            n_bad++;
        end
        sig = 4'b0000;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend, ovf} !== {1'b1, 2'd1, EVT_RISE, 4'b0010, 4'b0000}) begin
            $display("FAIL ovf_hold: valid=%b ch=%0d fall=%b pend=%b ovf=%b, want 1/1/0/0010/0000",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend, ovf);
            n_bad++;
        end
        // Second rise overflows; the concurrent clear must lose to the set.
        sig = 4'b0010;
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend, ovf} !== {1'b1, 2'd1, EVT_RISE, 4'b0010, 4'b0010}) begin
            $display("FAIL ovf_set: valid=%b ch=%0d fall=%b pend=%b ovf=%b, want 1/1/0/0010/0010",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend, ovf);
            n_bad++;
        end
        evt_if.evt_ready = 1'b1;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend} !== {1'b1, 2'd1, EVT_FALL, 4'b0000}) begin
            $display("FAIL ovf_second: valid=%b ch=%0d fall=%b pend=%b, want 1/1/1/0000",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, ovf} !== 5'b0_0010) begin
            $display("FAIL ovf_sticky: valid=%b ovf=%b, want 0/0010", evt_if.evt_valid, ovf);
            n_bad++;
        end
        ovf_clr = 4'b0010;
        tick();
        ovf_clr = 4'b0000;
        n_cmp++;
        if (ovf !== 4'b0000) begin
            $display("FAIL ovf_clear: ovf=%b, want 0000", ovf);
            n_bad++;
        end
    endtask

    task automatic test_enable_and_reset();
        // Raise ch0 with both edges masked, then allow only rising edges.
        en_rise = 4'b1110;
        en_fall = 4'b1110;
        sig = 4'b0011;
        tick();
        en_rise = 4'b1111;
        sig = 4'b0010;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, pend} !== 5'b0_0000) begin
            $display("FAIL fall_masked: valid=%b pend=%b, want 0/0000", evt_if.evt_valid, pend);
            n_bad++;
        end
        // ch0 rises and ch1 falls together; pointer is at ch1 so ch0 wins.
        evt_if.evt_ready = 1'b0;
        sig = 4'b0001;
        tick();
        n_cmp++;
        if (pend !== 4'b0011) begin
            $display("FAIL dual_pend: pend=%b, want 0011", pend);
            n_bad++;
        end
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend} !== {1'b1, 2'd0, EVT_RISE, 4'b0010}) begin
            $display("FAIL rise_only: valid=%b ch=%0d fall=%b pend=%b, want 1/0/0/0010",
                     evt_if.evt_valid, evt_if.evt_ch, evt_if.evt_fall, pend);
            n_bad++;
        end
        rst = 1'b1;
        evt_if.evt_ready = 1'b1;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, pend, ovf} !== 9'b0_0000_0000) begin
            $display("FAIL mid_reset: valid=%b pend=%b ovf=%b, want 0/0000/0000", evt_if.evt_valid, pend, ovf);
            n_bad++;
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({evt_if.evt_valid, pend} !== 5'b0_0000) begin
            $display("FAIL post_reset: valid=%b pend=%b, want 0/0000", evt_if.evt_valid, pend);
            n_bad++;
        end
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_burst();
        test_overflow();
        test_enable_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
